stepper_seq_ctrl: RTL and testbench

//  Parametrised 4-coil stepper sequencer. Issues a commanded number of steps at a programmable period.

---
 rtl/stepper_seq_ctrl_pkg.sv | 40 ++++
 rtl/stepper_seq_ctrl_if.sv | 22 ++
 rtl/stepper_seq_ctrl_step_tick_gen.sv | 27 ++
 rtl/stepper_seq_ctrl.sv | 117 +++++++++++
 tb/tb_stepper_seq_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/stepper_seq_ctrl_pkg.sv
// Shared types and constants for the 4-coil stepper sequencer.
// Coil bit order: bit0=A, bit1=B, bit2=A', bit3=B'.
package stepper_pkg;

    typedef enum logic [1:0] {
        MODE_WAVE = 2'b00,
        MODE_FULL = 2'b01,
        MODE_HALF = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam int unsigned MIN_PERIOD = 2;

    // idx 0..7: A, AB, B, BA', A', A'B', B', B'A
    localparam logic [3:0] PHASE_TABLE [8] = '{
        4'b0001, 4'b0011, 4'b0010, 4'b0110,
        4'b0100, 4'b1100, 4'b1000, 4'b1001
    };

    // Wave sits on even (single-coil) entries, full on odd (two-coil) entries;
    // the reserved mode behaves as full.
    function automatic logic [2:0] next_idx(input logic [2:0] idx,
                                            input logic       dir,
                                            input mode_e      mode);
        logic [2:0] n;
        if (mode == MODE_HALF) begin
            n = dir ? idx + 3'd1 : idx - 3'd1;
        end else begin
            n    = dir ? idx + 3'd2 : idx - 3'd2;
            n[0] = (mode != MODE_WAVE);
        end
        return n;
    endfunction

endpackage

// File: rtl/stepper_seq_ctrl_if.sv
// Command handshake between the register slave (master side) and the sequencer (slave side).
interface stepper_seq_ctrl_if #(
    parameter int unsigned DIV_W  = 32,
    parameter int unsigned STEP_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [STEP_W-1:0] cmd_steps;
    logic              cmd_dir;
    logic [1:0]        cmd_mode;
    logic [DIV_W-1:0]  cmd_period;

    modport master (
        output cmd_valid, cmd_steps, cmd_dir, cmd_mode, cmd_period,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_steps, cmd_dir, cmd_mode, cmd_period,
        output cmd_ready
    );
endinterface

// File: rtl/stepper_seq_ctrl_step_tick_gen.sv
// Step-period divider: counts 0..period-1 while enabled and flags the last count.
module step_tick_gen #(
    parameter int unsigned DIV_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] period_i,
    output logic             tick_o
);
    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q;

    assign tick_o = en_i && !clear_i && (cnt_q == period_i - ONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= tick_o ? '0 : cnt_q + ONE;
        end
    end
endmodule

// File: rtl/stepper_seq_ctrl.sv
// 4-coil stepper sequencer: runs a commanded number of steps at a programmable period
// in wave/full/half mode, with abort, holding torque and a wrapping signed position.
module stepper_seq_ctrl
    import stepper_pkg::*;
#(
    parameter int unsigned DIV_W  = 32,
    parameter int unsigned STEP_W = 16,
    parameter int unsigned POS_W  = 24
) (
    input  logic                    clock_clk,
    input  logic                    reset_reset,
    stepper_seq_ctrl_if.slave       cmd,
    input  logic                    abort,
    input  logic                    hold_en,
    output logic [3:0]              coil_en,
    output logic [1:0]              bridge_en,
    output logic                    busy,
    output logic                    done,
    output logic signed [POS_W-1:0] position
);
    localparam logic [DIV_W-1:0]  MIN_P    = DIV_W'(MIN_PERIOD);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
    localparam logic [POS_W-1:0]  POS_ONE  = POS_W'(1);

    state_e            state_q;
    mode_e             mode_q;
    logic              dir_q;
    logic [2:0]        idx_q;
    logic [POS_W-1:0]  pos_q;
    logic [STEP_W-1:0] steps_left_q;
    logic [DIV_W-1:0]  period_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic [3:0]        coil_q;
    logic [1:0]        bridge_q;

    logic       accept;
    logic       tick;
    logic       finish;
    logic       step_now;
    logic       run_d;
    logic [2:0] idx_d;

    assign accept   = (state_q == S_IDLE) && ready_q && cmd.cmd_valid;
    // An empty steps_left in RUN is the one-cycle tail after the final step.
    assign finish   = (state_q == S_RUN) && (abort || (steps_left_q == '0));
    assign step_now = (state_q == S_RUN) && !finish && tick;
    assign run_d    = (state_q == S_IDLE) ? (accept && (cmd.cmd_steps != '0)) : !finish;
    assign idx_d    = step_now ? next_idx(idx_q, dir_q, mode_q) : idx_q;

    step_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk_i    (clock_clk),
        .rst_i    (reset_reset),
        .clear_i  (accept),
        .en_i     (state_q == S_RUN),
        .period_i (period_q),
        .tick_o   (tick)
    );

    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q      <= S_IDLE;
            mode_q       <= MODE_WAVE;
            dir_q        <= 1'b0;
            idx_q        <= '0;
            pos_q        <= '0;
            steps_left_q <= '0;
            period_q     <= MIN_P;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            coil_q       <= '0;
            bridge_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        steps_left_q <= cmd.cmd_steps;
                        dir_q        <= cmd.cmd_dir;
                        mode_q       <= mode_e'(cmd.cmd_mode);
                        period_q     <= (cmd.cmd_period < MIN_P) ? MIN_P : cmd.cmd_period;
                        if (cmd.cmd_steps == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (finish) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end else if (step_now) begin
                        pos_q        <= dir_q ? pos_q + POS_ONE : pos_q - POS_ONE;
                        steps_left_q <= steps_left_q - STEP_ONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            idx_q    <= idx_d;
            ready_q  <= !run_d;
            busy_q   <= run_d;
            coil_q   <= (run_d || hold_en) ? PHASE_TABLE[idx_d] : '0;
            bridge_q <= (run_d || hold_en) ? 2'b11 : 2'b00;
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign coil_en       = coil_q;
    assign bridge_en     = bridge_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign position      = pos_q;
endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// Directed self-checking bench for stepper_seq_ctrl; outputs sampled on the falling edge.
module tb_stepper_seq_ctrl;
    localparam int unsigned DIV_W  = 32;
    localparam int unsigned STEP_W = 16;
    localparam int unsigned POS_W  = 24;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             abort = 1'b0;
    logic             hold_en = 1'b0;
    logic [3:0]       coil_en;
    logic [1:0]       bridge_en;
    logic             busy;
    logic             done;
    logic [POS_W-1:0] position;

    int unsigned total  = 0;
    int unsigned passed = 0;

    stepper_seq_ctrl_if #(.DIV_W(DIV_W), .STEP_W(STEP_W)) cmd_if ();

    stepper_seq_ctrl #(.DIV_W(DIV_W), .STEP_W(STEP_W), .POS_W(POS_W)) dut (
        .clock_clk   (clk),
        .reset_reset (rst),
        .cmd         (cmd_if.slave),
        .abort       (abort),
        .hold_en     (hold_en),
        .coil_en     (coil_en),
        .bridge_en   (bridge_en),
        .busy        (busy),
        .done        (done),
        .position    (position)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_neg(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; returns on the falling edge just after the accept edge.
    task automatic send_cmd(input logic [STEP_W-1:0] steps, input logic dir,
                            input logic [1:0] mode, input logic [DIV_W-1:0] period);
        check("ready_before_cmd", 32'(cmd_if.cmd_ready), 32'd1);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_steps  = steps;
        cmd_if.cmd_dir    = dir;
        cmd_if.cmd_mode   = mode;
        cmd_if.cmd_period = period;
        @(negedge clk);
        cmd_if.cmd_valid  = 1'b0;
    endtask

    initial begin
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_steps  = '0;
        cmd_if.cmd_dir    = 1'b0;
        cmd_if.cmd_mode   = 2'b00;
        cmd_if.cmd_period = '0;

        // Reset state
        wait_neg(2);
        check("rst_coil", 32'(coil_en), 32'h0);
        check("rst_bridge", 32'(bridge_en), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_pos", 32'(position), 32'h0);
        check("rst_ready", 32'(cmd_if.cmd_ready), 32'h0);
        rst = 1'b0;
        #1 check("ready_before_edge", 32'(cmd_if.cmd_ready), 32'h0);
        wait_neg(1);
        check("ready_after_release", 32'(cmd_if.cmd_ready), 32'h1);
        check("idle_nohold_coil", 32'(coil_en), 32'h0);

        // Full, reverse, 2 steps, period 2 from idx0: 7 (B'A) then 5 (A'B')
        hold_en = 1'b1;
        send_cmd(16'd2, 1'b0, 2'b01, 32'd2);
        check("full_busy", 32'(busy), 32'h1);
        check("full_ready_low", 32'(cmd_if.cmd_ready), 32'h0);
        check("full_coil0", 32'(coil_en), 32'b0001);
        check("full_bridge", 32'(bridge_en), 32'b11);
        wait_neg(1);
        check("full_coil_p1", 32'(coil_en), 32'b0001);
        wait_neg(1);
        check("full_coil_p2", 32'(coil_en), 32'b1001);
        check("full_pos_p2", 32'(position), 32'hFF_FFFF);
        wait_neg(2);
        check("full_coil_p4", 32'(coil_en), 32'b1100);
        check("full_pos_p4", 32'(position), 32'hFF_FFFE);
        check("full_done_p4", 32'(done), 32'h0);
        wait_neg(1);
        check("full_done_p5", 32'(done), 32'h1);
        check("full_busy_p5", 32'(busy), 32'h0);
        check("full_hold_coil", 32'(coil_en), 32'b1100);
        wait_neg(1);
        check("full_done_p6", 32'(done), 32'h0);

        // Zero-step command
        send_cmd(16'd0, 1'b1, 2'b10, 32'd5);
        check("zero_done", 32'(done), 32'h1);
        check("zero_busy", 32'(busy), 32'h0);
        check("zero_coil", 32'(coil_en), 32'b1100);
        wait_neg(1);
        check("zero_done_clr", 32'(done), 32'h0);
        check("zero_pos", 32'(position), 32'hFF_FFFE);

        // Reset pulse back to idx0
        rst = 1'b1;
        #1 check("rst2_pos", 32'(position), 32'h0);
        wait_neg(1);
        rst = 1'b0;
        wait_neg(1);
        check("rst2_hold_coil", 32'(coil_en), 32'b0001);

        // Half, forward, 3 steps, period 4
        send_cmd(16'd3, 1'b1, 2'b10, 32'd4);
        check("half_coil0", 32'(coil_en), 32'b0001);
        wait_neg(3);
        check("half_coil_p3", 32'(coil_en), 32'b0001);
        wait_neg(1);
        check("half_coil_p4", 32'(coil_en), 32'b0011);
        wait_neg(4);
        check("half_coil_p8", 32'(coil_en), 32'b0010);
        wait_neg(4);
        check("half_coil_p12", 32'(coil_en), 32'b0110);
        check("half_done_p12", 32'(done), 32'h0);
        wait_neg(1);
        check("half_done_p13", 32'(done), 32'h1);
        check("half_busy_p13", 32'(busy), 32'h0);
        check("half_pos", 32'(position), 32'h3);

        // Abort on the second tick of a 5-step move
        send_cmd(16'd5, 1'b1, 2'b10, 32'd3);
        wait_neg(3);
        check("abort_step1_coil", 32'(coil_en), 32'b0100);
        wait_neg(2);
        abort = 1'b1;
        wait_neg(1);
        abort = 1'b0;
        check("abort_done", 32'(done), 32'h1);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_coil", 32'(coil_en), 32'b0100);
        check("abort_pos", 32'(position), 32'h4);
        hold_en = 1'b0;
        wait_neg(1);
        check("nohold_coil", 32'(coil_en), 32'h0);
        check("nohold_bridge", 32'(bridge_en), 32'h0);
        wait_neg(6);
        check("abort_pos_later", 32'(position), 32'h4);

        // Reset mid-move, then a 1-step half command
        hold_en = 1'b1;
        send_cmd(16'd5, 1'b1, 2'b10, 32'd2);
        wait_neg(2);
        check("mid_coil", 32'(coil_en), 32'b1100);
        wait_neg(1);
        rst = 1'b1;
        #1;
        check("mid_rst_coil", 32'(coil_en), 32'h0);
        check("mid_rst_bridge", 32'(bridge_en), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_pos", 32'(position), 32'h0);
        check("mid_rst_ready", 32'(cmd_if.cmd_ready), 32'h0);
        wait_neg(1);
        rst = 1'b0;
        wait_neg(1);
        send_cmd(16'd1, 1'b1, 2'b10, 32'd2);
        wait_neg(2);
        check("post_rst_coil", 32'(coil_en), 32'b0011);
        check("post_rst_pos", 32'(position), 32'h1);
        wait_neg(1);
        check("post_rst_done", 32'(done), 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
